// File: rtl/conv_pkg.sv
// Shared types and constants for the convolver stream adapter.
// The optional ReLU clamp in conv_stream_adapter is enabled by defining CONV_ADAPTER_RELU_EN.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } conv_state_e;

    localparam int unsigned CONV_N      = 4;
    localparam int unsigned CONV_K_SIZE = 3;

    function automatic int unsigned out_dim(input int unsigned n, input int unsigned k);
        return n - k + 1;
    endfunction

    function automatic int unsigned out_count(input int unsigned n, input int unsigned k);
        return out_dim(n, k) * out_dim(n, k);
    endfunction

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int unsigned width_of(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    localparam int unsigned OUT_DIM   = out_dim(CONV_N, CONV_K_SIZE);
    localparam int unsigned OUT_COUNT = out_count(CONV_N, CONV_K_SIZE);

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous first-word-fall-through FIFO holding cropped results plus their frame-last bit.
module conv_out_fifo
    import conv_pkg::*;
#(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = width_of(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_wr = wr_en & ~full;
        do_rd = rd_en & ~empty;
        // Pointers wrap for free because DEPTH is a power of two.
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/conv_stream_adapter.sv
// Stream wrapper around a KxK line-buffered convolver: feeds pixels, crops valid windows, buffers results.
// Define CONV_ADAPTER_RELU_EN to clamp negative results to zero before buffering.
module conv_stream_adapter
    import conv_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned K_SIZE     = 3,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LAT        = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  conv_en,
    output logic [DATA_WIDTH-1:0] conv_data,
    input  logic [DATA_WIDTH-1:0] conv_result,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int unsigned CW = width_of(N);
    localparam int unsigned LW = (LAT > 0) ? LAT : 1;
    localparam int unsigned FW = width_of(LAT);
    localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
    localparam logic [CW-1:0] FIRST_VLD = CW'(K_SIZE - 1);
    localparam logic [FW-1:0] FLUSH_END = FW'((LAT > 0) ? LAT - 1 : 0);

    conv_state_e          state_q, state_d;
    logic [CW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
    logic [LW-1:0]        flag_pipe_q, flag_pipe_d;
    logic [LW-1:0]        last_pipe_q, last_pipe_d;
    logic                 accept, frame_end, pos_flag, pos_last;
    logic                 out_flag, out_last;
    logic                 fifo_full, fifo_empty, fifo_wr;
    logic [DATA_WIDTH-1:0] wr_value;
    logic [DATA_WIDTH:0]  fifo_wdata, fifo_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN: begin
                if (accept && frame_end) begin
                    state_d = (LAT == 0) ? ST_RUN : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (conv_en && (flush_cnt_q == FLUSH_END)) begin
                    state_d = ST_RUN;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s_ready   = 1'b0;
        conv_en   = 1'b0;
        conv_data = '0;
        case (state_q)
            ST_RUN: begin
                s_ready   = ~fifo_full;
                conv_en   = s_valid & ~fifo_full;
                conv_data = s_data;
            end
            ST_FLUSH: begin
                conv_en = ~fifo_full;
            end
            default: ;
        endcase
    end

    assign accept    = (state_q == ST_RUN) && conv_en;
    assign frame_end = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign pos_flag  = (state_q == ST_RUN) && (row_q >= FIRST_VLD) && (col_q >= FIRST_VLD);
    assign pos_last  = (state_q == ST_RUN) && frame_end;

    // Wrapping on the last pixel leaves row/col at zero, ready for the frame after the flush.
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        flush_cnt_d = flush_cnt_q;
        if (accept) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        if ((state_q == ST_FLUSH) && conv_en) begin
            flush_cnt_d = (flush_cnt_q == FLUSH_END) ? '0 : flush_cnt_q + FW'(1);
        end
    end

    always_comb begin
        flag_pipe_d = flag_pipe_q;
        last_pipe_d = last_pipe_q;
        if (conv_en) begin
            flag_pipe_d[0] = pos_flag;
            last_pipe_d[0] = pos_last;
            for (int unsigned i = 1; i < LW; i++) begin
                flag_pipe_d[i] = flag_pipe_q[i-1];
                last_pipe_d[i] = last_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            flush_cnt_q <= '0;
            flag_pipe_q <= '0;
            last_pipe_q <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            flush_cnt_q <= flush_cnt_d;
            flag_pipe_q <= flag_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    // The result on conv_result belongs to the pixel whose flag is leaving the pipe.
    assign out_flag = (LAT == 0) ? pos_flag : flag_pipe_q[LW-1];
    assign out_last = (LAT == 0) ? pos_last : last_pipe_q[LW-1];
    assign fifo_wr  = conv_en & out_flag;

`ifdef CONV_ADAPTER_RELU_EN
    assign wr_value = conv_result[DATA_WIDTH-1] ? '0 : conv_result;
`else
    assign wr_value = conv_result;
`endif

    assign fifo_wdata = {out_last, wr_value};

    conv_out_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (m_ready),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_valid = ~fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
    assign m_last  = ~fifo_empty & fifo_rdata[DATA_WIDTH];

endmodule

// File: tb/tb_conv_stream_adapter.sv
// Self-checking bench for conv_stream_adapter with a behavioural 3x3 convolver (LAT=1) attached.
module tb_conv_stream_adapter;

    localparam int N  = 4;
    localparam int K  = 3;
    localparam int DW = 16;
    localparam int H  = N * (K - 1) + K;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          conv_en;
    logic [DW-1:0] conv_data;
    logic [DW-1:0] conv_result;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;

    always #5 clk = ~clk;

    conv_stream_adapter #(
        .N          (N),
        .K_SIZE     (K),
        .DATA_WIDTH (DW),
        .LAT        (1),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .conv_en     (conv_en),
        .conv_data   (conv_data),
        .conv_result (conv_result),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    // Convolver model: uniform kernel coefficient, line-buffer history, result one en-cycle later.
    int                   kern;
    logic signed [DW-1:0] hist [H];
    logic signed [DW-1:0] tmp  [H];
    int                   acc;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < H; i++) hist[i] <= '0;
            conv_result <= '0;
        end else if (conv_en) begin
            tmp[0] = conv_data;
            for (int i = 1; i < H; i++) tmp[i] = hist[i-1];
            acc = 0;
            for (int dr = 0; dr < K; dr++)
                for (int dc = 0; dc < K; dc++)
                    acc += kern * int'(tmp[dr*N + dc]);
            for (int i = 0; i < H; i++) hist[i] <= tmp[i];
            conv_result <= acc[DW-1:0];
        end
    end

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } out_t;

    out_t outq[$];
    int   en_cnt, acc_cnt, viol_cnt;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) outq.push_back({m_last, m_data});
            if (conv_en) en_cnt++;
            if (conv_en && s_ready) acc_cnt++;
            if (conv_en && s_ready && !s_valid) viol_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_pixel(input logic [DW-1:0] v, input bit gap);
        int n;
        n       = 0;
        s_data  = v;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = '0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int base, input int step, input bit gap, input int count);
        for (int i = 0; i < count; i++) send_pixel(DW'(base + step * i), gap);
    endtask

    task automatic wait_outputs(input int n);
        int c;
        c = 0;
        while (outq.size() < n && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (outq.size() < n) chk("output_timeout", outq.size(), n);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0][DW-1:0] exp, input int frames);
        chk({tag, "_count"}, outq.size(), 4 * frames);
        for (int i = 0; i < 4 * frames && i < outq.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), outq[i].data, exp[i % 4]);
            chk($sformatf("%s_last%0d", tag, i), outq[i].last, (i % 4) == 3);
        end
    endtask

    typedef struct {
        int                   kern;
        int                   base;
        int                   step;
        logic [3:0][DW-1:0]   exp;
    } vec_t;

    function automatic vec_t mk(input int k, input int b, input int s,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.kern   = k;
        v.base   = b;
        v.step   = s;
        v.exp[0] = DW'(e0);
        v.exp[1] = DW'(e1);
        v.exp[2] = DW'(e2);
        v.exp[3] = DW'(e3);
        return v;
    endfunction

    vec_t               vecs[5];
    logic [3:0][DW-1:0] ramp;
    int                 neg_exp;

    initial begin
`ifdef CONV_ADAPTER_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -9;
`endif
        // Windows ending at (2,2),(2,3),(3,2),(3,3) of a 4x4 raster.
        vecs[0] = mk( 1, 1, 1,  54,  63,  90,  99);
        vecs[1] = mk( 2, 1, 1, 108, 126, 180, 198);
        vecs[2] = mk( 1, 3, 0,  27,  27,  27,  27);
        vecs[3] = mk(-1, 1, 0, neg_exp, neg_exp, neg_exp, neg_exp);
        vecs[4] = mk( 1, 0, 1,  45,  54,  81,  90);
        ramp    = vecs[0].exp;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        kern    = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_conv_en", conv_en, 0);
        chk("rst_conv_data", conv_data, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        rst = 1'b0;
        chk("idle_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        chk("run_s_ready", s_ready, 1);

        for (int v = 0; v < 5; v++) begin
            kern   = vecs[v].kern;
            outq.delete();
            en_cnt = 0;
            send_frame(vecs[v].base, vecs[v].step, 1'b0, 16);
            wait_outputs(4);
            check_outputs($sformatf("vec%0d", v), vecs[v].exp, 1);
            chk($sformatf("vec%0d_en_cycles", v), en_cnt, 17);
        end

        // Two back-to-back frames with s_valid toggling.
        kern     = 1;
        outq.delete();
        en_cnt   = 0;
        viol_cnt = 0;
        send_frame(1, 1, 1'b1, 16);
        send_frame(1, 1, 1'b1, 16);
        wait_outputs(8);
        check_outputs("toggle", ramp, 2);
        chk("toggle_en_cycles", en_cnt, 34);
        chk("toggle_en_without_valid", viol_cnt, 0);

        // Backpressure: depth-2 FIFO fills, input stalls, nothing lost.
        outq.delete();
        acc_cnt = 0;
        m_ready = 1'b0;
        fork
            send_frame(1, 1, 1'b0, 16);
            begin
                repeat (40) @(posedge clk);
                #1;
                chk("bp_accepted", acc_cnt, 13);
                chk("bp_s_ready", s_ready, 0);
                chk("bp_m_valid", m_valid, 1);
                chk("bp_head", m_data, 54);
                @(posedge clk);
                #1;
                chk("bp_head_stable", m_data, 54);
                chk("bp_last_stable", m_last, 0);
                m_ready = 1'b1;
            end
        join
        wait_outputs(4);
        check_outputs("bp", ramp, 1);

        // Reset mid-frame with one result already buffered.
        outq.delete();
        m_ready = 1'b0;
        send_frame(1, 1, 1'b0, 12);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_m_valid", m_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        rst = 1'b0;
        chk("post_rst_idle", s_ready, 0);
        @(posedge clk);
        #1;
        chk("post_rst_run", s_ready, 1);
        m_ready = 1'b1;
        outq.delete();
        en_cnt = 0;
        send_frame(1, 1, 1'b0, 16);
        wait_outputs(4);
        check_outputs("replay", ramp, 1);
        chk("replay_en_cycles", en_cnt, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
